// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer: sequential SRAM reader feeding a valid/ready stream.
// Optional stall counter enabled by defining SRAM_RD_STREAMER_STATS_EN.
module sram_rd_streamer #(
    parameter int ADR_W  = 10,
    parameter int SRAM_W = 128,
    parameter int FIFO_D = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [ADR_W-1:0]  i_base_addr,
    input  logic [ADR_W:0]    i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cen,
    output logic              o_rdwen,
    output logic [ADR_W-1:0]  o_addr,
    output logic [SRAM_W-1:0] o_wmask,
    output logic [SRAM_W-1:0] o_indata,
    input  logic [SRAM_W-1:0] i_outdata,
    output logic [SRAM_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last,
    input  logic              i_ready,
    output logic [31:0]       o_stall_cnt
);

    localparam int CNT_W = $clog2(FIFO_D + 1);
    localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam logic [CNT_W:0] DEPTH = (CNT_W + 1)'(FIFO_D);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_D - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    state_e             state_q;
    logic [ADR_W-1:0]   base_q;
    logic [ADR_W:0]     len_q;
    logic [ADR_W:0]     issued_q;
    logic [ADR_W:0]     popped_q;
    logic               inflight_q;
    logic               done_q;

    logic [SRAM_W-1:0]  fifo_q [FIFO_D];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic               push;
    logic               pop;
    logic               issue;
    logic [CNT_W:0]     credit;
    logic [CNT_W:0]     limit;

    // A pop in the same cycle frees a slot, so it widens the issue window.
    always_comb begin
        push   = inflight_q;
        pop    = o_valid & i_ready;
        credit = {{CNT_W{1'b0}}, inflight_q} + {1'b0, count_q};
        limit  = DEPTH + {{CNT_W{1'b0}}, pop};
        issue  = (state_q == ISSUE) && (credit < limit);
    end

    assign o_valid  = (count_q != '0);
    assign o_data   = fifo_q[rd_ptr_q];
    assign o_last   = o_valid && (popped_q == len_q - 1'b1);
    assign o_cen    = ~issue;
    assign o_addr   = base_q + issued_q[ADR_W-1:0];
    assign o_busy   = (state_q != IDLE) | done_q;
    assign o_done   = done_q;
    assign o_rdwen  = 1'b1;
    assign o_wmask  = '0;
    assign o_indata = '0;

    // Transfer control: latch request, count issues and pops, pulse done.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            if (pop) begin
                popped_q <= popped_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            base_q   <= i_base_addr;
                            len_q    <= i_len;
                            issued_q <= '0;
                            popped_q <= '0;
                            state_q  <= ISSUE;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        issued_q <= issued_q + 1'b1;
                        if (issued_q + 1'b1 == len_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (popped_q + 1'b1 == len_q)) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output FIFO: capture read data one edge after issue, pop on handshake.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < FIFO_D; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= i_outdata;
                wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

`ifdef SRAM_RD_STREAMER_STATS_EN
    logic [31:0] stall_q;

    // Count backpressure edges; cleared by an accepted start, saturating.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stall_q <= '0;
        end else if (state_q == IDLE && i_start) begin
            stall_q <= '0;
        end else if (o_valid && !i_ready && stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign o_stall_cnt = stall_q;
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: doc/sram_rd_streamer.md
Name: sram_rd_streamer

Overview:
- Read-side initiator for the on-chip single-port SRAM macro interface (active-low chip enable, active-low write enable, per-byte write mask, 1-cycle registered read data).
- Given a base address and a word count, issues sequential SRAM reads and returns the words as a valid/ready stream with full backpressure support.
- Sits between a tile SRAM and the downstream feeder/compute datapath; a small credit-controlled FIFO absorbs the SRAM read latency.

Parameters:
ADR_W, 10, SRAM address width in words.
SRAM_W, 128, SRAM word width in bits; multiple of 8.
FIFO_D, 2, output FIFO depth in words; minimum 2, which is required for 1 word/cycle throughput.

Ports:
i_clk  input  1  clock
i_rstn  input  1  asynchronous active-low reset
i_start  input  1  start pulse; sampled only in IDLE
i_base_addr  input  ADR_W  first word address
i_len  input  ADR_W+1  number of words to read; 0 = no-op
o_busy  output  1  high from the start edge until the done pulse, inclusive
o_done  output  1  1-cycle pulse after the last word handshakes
o_cen  output  1  SRAM chip enable, active low
o_rdwen  output  1  SRAM write enable, active low; tied 1 (read only)
o_addr  output  ADR_W  SRAM address
o_wmask  output  SRAM_W  SRAM write mask; tied 0
o_indata  output  SRAM_W  SRAM write data; tied 0
i_outdata  input  SRAM_W  SRAM read data, valid in the cycle after the read edge
o_data  output  SRAM_W  stream data, equal to the FIFO head
o_valid  output  1  stream valid
o_last  output  1  qualifies the final word of the transfer
i_ready  input  1  stream ready
o_stall_cnt  output  32  backpressure stall counter (see Optional Feature)

Behaviour:
Reset values:
- State IDLE, FIFO empty.
- o_cen=1, o_addr=0, o_busy=0, o_done=0, o_valid=0, o_last=0, o_data=0, o_stall_cnt=0.
- Reset asserted mid-transfer aborts immediately: in-flight read dropped, FIFO flushed, no done pulse.

FSM states: IDLE, ISSUE, DRAIN.
- IDLE: i_start=1 with i_len!=0 latches base and len, resets issue and pop counters, goes to ISSUE. i_start=1 with i_len=0 goes straight to a done pulse (o_busy and o_done both high for 1 cycle), no SRAM access.
- ISSUE: o_cen=0 and o_addr=base+issued (mod 2^ADR_W; wraps from 2^ADR_W-1 to 0) whenever credit is available. A read counts as issued at each edge where o_cen=0. After len reads have been issued, goes to DRAIN.
- DRAIN: waits until popped==len, then pulses o_done and returns to IDLE.
- i_start is ignored while not in IDLE.

Credit rule:
- Define credit = inflight + fifo_count, where inflight is 0 or 1.
- Issue is allowed only if credit < FIFO_D, counting a pop in the same cycle (pop frees a slot combinationally).
- The FIFO therefore never overflows, and the SRAM is never stalled.

Capture:
- A read issued at edge E is written into the FIFO at edge E+1 from i_outdata.

Stream:
- o_valid = FIFO not empty. A handshake is o_valid & i_ready at the edge.
- o_data and o_last are held stable while o_valid & !i_ready.
- o_last=1 only on the word with index len-1.

Latency:
- i_start sampled at edge T0.
- First o_cen=0 in the cycle following T0; first read edge T1; o_valid rises after T2.
- With i_ready held at 1: one word per cycle, and o_done is high in the cycle after the final handshake.

Other rules:
- Simultaneous push and pop on a full FIFO is legal, and occupancy is unchanged.
- Counters are ADR_W+1 bits wide, so len=2^ADR_W is supported.

Optional Feature:
- Macro: SRAM_RD_STREAMER_STATS_EN.
- Defined: o_stall_cnt increments at each edge where o_valid=1 and i_ready=0. It clears on the accepted i_start and saturates at 2^32-1.
- Undefined: no counter logic; o_stall_cnt is tied to 0.

Test Plan:
- SRAM preloaded mem[k]=k, base=0x010, len=4, i_ready=1 -> o_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles, o_last on 0x13, o_done pulse on the next cycle, exactly 4 cycles with o_cen=0.
- base=0x3FE, len=4 (ADR_W=10) -> o_addr sequence 0x3FE,0x3FF,0x000,0x001; data is returned in that order.
- len=8, i_ready toggling 1,0,0,1 repeating -> all 8 words delivered in order with none lost or duplicated; o_data stable through the stalls; FIFO occupancy never exceeds 2; o_stall_cnt=8 with the macro defined, 0 without.
- i_start with len=0 -> o_busy and o_done high for 1 cycle, o_cen held at 1 throughout. i_start pulsed during a busy len=4 transfer -> ignored, exactly 4 words delivered.
- i_rstn deasserted after 2 of 6 words have handshaked -> next cycle o_valid=0, o_cen=1, o_busy=0, no o_done. A new start with base=0, len=2 then delivers mem[0], mem[1] correctly.
- len=1024 from base=0, i_ready=1 -> 1024 words, throughput 1 word/cycle, o_done exactly 1026 cycles after the start edge.
